// File: rtl/count_stream_checker.sv
// count_stream_checker
// Receive-side monitor for a free-running binary up-counter bus. It locks
// onto the sequence after SYNC_LEN consecutive correct increments. While
// locked, any sample that is not previous+1 (mod 2^WIDTH) is reported as an
// error. The block keeps a saturating error count and captures the first
// failure since the last clear or reset.
module count_stream_checker #(
    parameter int WIDTH     = 16,
    parameter int ERR_CNT_W = 8,
    parameter int SYNC_LEN  = 2     // legal range 1..15
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 count_valid,
    input  logic [WIDTH-1:0]     count,
    input  logic                 clear,
    output logic                 locked,
    output logic                 mismatch,
    output logic                 error_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     exp_count,
    output logic [WIDTH-1:0]     first_bad,
    output logic [WIDTH-1:0]     first_exp
);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam logic [3:0]           SYNC_LEN_C = 4'(SYNC_LEN);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

    state_t               state_q;
    logic [WIDTH-1:0]     prev_q;
    logic [3:0]           good_run_q;
    logic                 locked_q;
    logic                 mismatch_q;
    logic                 sticky_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [WIDTH-1:0]     first_bad_q;
    logic [WIDTH-1:0]     first_exp_q;

    logic [WIDTH-1:0]     exp_next_d;
    logic [3:0]           run_inc_d;
    logic                 match_d;
    logic                 err_d;

    // Next expected value and the sequence-error decision for this edge.
    // The adder wraps from all-ones to 0.
    always_comb begin
        exp_next_d = prev_q + WIDTH'(1);
        run_inc_d  = good_run_q + 4'd1;
        match_d    = (count == exp_next_d);
        err_d      = count_valid && (state_q == ST_LOCK) && !match_d;
    end

    // Tracking FSM together with the registered status and error statistics.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_HUNT;
            prev_q      <= '0;
            good_run_q  <= '0;
            locked_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            sticky_q    <= 1'b0;
            err_cnt_q   <= '0;
            first_bad_q <= '0;
            first_exp_q <= '0;
        end else begin
            mismatch_q <= err_d;

            if (count_valid) begin
                prev_q <= count;
                case (state_q)
                    ST_HUNT: begin
                        good_run_q <= '0;
                        state_q    <= ST_SYNC;
                        locked_q   <= 1'b0;
                    end
                    ST_SYNC: begin
                        if (match_d) begin
                            if (run_inc_d == SYNC_LEN_C) begin
                                state_q    <= ST_LOCK;
                                locked_q   <= 1'b1;
                                good_run_q <= '0;
                            end else begin
                                good_run_q <= run_inc_d;
                            end
                        end else begin
                            good_run_q <= '0;
                        end
                    end
                    ST_LOCK: begin
                        if (!match_d) begin
                            state_q    <= ST_SYNC;
                            locked_q   <= 1'b0;
                            good_run_q <= '0;
                        end
                    end
                    default: begin
                        state_q    <= ST_HUNT;
                        locked_q   <= 1'b0;
                        good_run_q <= '0;
                    end
                endcase
            end

            // A clear wipes the statistics first. An error on the same edge is
            // then applied on top of the wiped state, so it counts as the first
            // error again.
            if (clear) begin
                sticky_q    <= 1'b0;
                err_cnt_q   <= '0;
                first_bad_q <= '0;
                first_exp_q <= '0;
            end
            if (err_d) begin
                sticky_q <= 1'b1;
                if (clear) begin
                    err_cnt_q <= ERR_CNT_W'(1);
                end else if (err_cnt_q != ERR_MAX) begin
                    err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                end
                if (clear || !sticky_q) begin
                    first_bad_q <= count;
                    first_exp_q <= exp_next_d;
                end
            end
        end
    end

    assign locked       = locked_q;
    assign mismatch     = mismatch_q;
    assign error_sticky = sticky_q;
    assign err_count    = err_cnt_q;
    assign exp_count    = (state_q == ST_HUNT) ? '0 : exp_next_d;
    assign first_bad    = first_bad_q;
    assign first_exp    = first_exp_q;

endmodule

// File: tb/tb_count_stream_checker.sv
// tb_count_stream_checker
// Directed stimulus for count_stream_checker. Each driven sample pushes the
// expected output vector into a scoreboard queue. That entry is popped and
// compared one edge later. Additional constant checks cover the key boundaries.
module tb_count_stream_checker;

    localparam int W  = 16;
    localparam int EW = 8;
    localparam int SL = 2;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          count_valid = 1'b0;
    logic [W-1:0]  count = '0;
    logic          clear = 1'b0;
    logic          locked;
    logic          mismatch;
    logic          error_sticky;
    logic [EW-1:0] err_count;
    logic [W-1:0]  exp_count;
    logic [W-1:0]  first_bad;
    logic [W-1:0]  first_exp;

    count_stream_checker #(
        .WIDTH     (W),
        .ERR_CNT_W (EW),
        .SYNC_LEN  (SL)
    ) dut (
        .clock        (clock),
        .resetN       (resetN),
        .count_valid  (count_valid),
        .count        (count),
        .clear        (clear),
        .locked       (locked),
        .mismatch     (mismatch),
        .error_sticky (error_sticky),
        .err_count    (err_count),
        .exp_count    (exp_count),
        .first_bad    (first_bad),
        .first_exp    (first_exp)
    );

    always #5 clock = ~clock;

    wire [58:0] obs_vec = {locked, mismatch, error_sticky, err_count,
                           exp_count, first_bad, first_exp};

    int checks   = 0;
    int failures = 0;
    int step     = 0;

    // Reference model state (0 = HUNT, 1 = SYNC, 2 = LOCK)
    int            m_state;
    logic [W-1:0]  m_prev;
    int            m_run;
    logic          m_mis;
    logic          m_sticky;
    logic [EW-1:0] m_ec;
    logic [W-1:0]  m_fb;
    logic [W-1:0]  m_fe;

    logic [58:0] sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_prev   = '0;
        m_run    = 0;
        m_mis    = 1'b0;
        m_sticky = 1'b0;
        m_ec     = '0;
        m_fb     = '0;
        m_fe     = '0;
    endtask

    function automatic logic [58:0] model_outputs();
        logic [W-1:0] xc;
        xc = (m_state == 0) ? 16'h0000 : W'(m_prev + 16'h0001);
        return {(m_state == 2), m_mis, m_sticky, m_ec, xc, m_fb, m_fe};
    endfunction

    // Drive one sample, advance the model, then compare one edge later.
    task automatic drive(input logic v, input logic [W-1:0] c, input logic clr);
        logic [W-1:0] x;
        logic         err;
        logic [58:0]  expv;
        count_valid = v;
        count       = c;
        clear       = clr;
        x   = W'(m_prev + 16'h0001);
        err = 1'b0;
        if (v) begin
            if (m_state == 0) begin
                m_run   = 0;
                m_state = 1;
            end else if (m_state == 1) begin
                if (c == x) begin
                    m_run = m_run + 1;
                    if (m_run == SL) begin
                        m_state = 2;
                        m_run   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                if (c != x) begin
                    err     = 1'b1;
                    m_state = 1;
                    m_run   = 0;
                end
            end
            m_prev = c;
        end
        m_mis = err;
        if (clr) begin
            m_sticky = 1'b0;
            m_ec     = '0;
            m_fb     = '0;
            m_fe     = '0;
        end
        if (err) begin
            if (!m_sticky) begin
                m_fb = c;
                m_fe = x;
            end
            m_sticky = 1'b1;
            if (m_ec != 8'hFF) m_ec = m_ec + 8'h01;
        end
        sb_q.push_back(model_outputs());
        @(posedge clock);
        #1;
        step++;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'd0, 64'd1);
        end else begin
            expv = sb_q.pop_front();
            chk($sformatf("step%0d", step), {5'd0, obs_vec}, {5'd0, expv});
        end
        $display("step=%0d valid=%0b count=%h clear=%0b locked=%0b mismatch=%0b sticky=%0b err_count=%h exp_count=%h first_bad=%h first_exp=%h",
                 step, v, c, clr, locked, mismatch, error_sticky, err_count,
                 exp_count, first_bad, first_exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] val;
        logic [W-1:0] bad;
        model_reset();

        // Reset state
        resetN = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", {5'd0, obs_vec}, 64'd0);
        resetN = 1'b1;

        // 1. Acquire lock from zero
        drive(1'b1, 16'h0000, 1'b0);
        drive(1'b1, 16'h0001, 1'b0);
        chk("t1_not_locked_yet", {63'd0, locked}, 64'd0);
        drive(1'b1, 16'h0002, 1'b0);
        chk("t1_locked", {63'd0, locked}, 64'd1);
        drive(1'b1, 16'h0003, 1'b0);
        chk("t1_exp_count", {48'd0, exp_count}, 64'h0004);
        chk("t1_no_mismatch", {63'd0, error_sticky}, 64'd0);

        // 2. Wrap through all-ones
        resetN = 1'b0;
        #1;
        resetN = 1'b1;
        model_reset();
        drive(1'b1, 16'hFFFB, 1'b0);
        drive(1'b1, 16'hFFFC, 1'b0);
        drive(1'b1, 16'hFFFD, 1'b0);
        drive(1'b1, 16'hFFFE, 1'b0);
        drive(1'b1, 16'hFFFF, 1'b0);
        chk("t2_exp_wrap", {48'd0, exp_count}, 64'h0000);
        drive(1'b1, 16'h0000, 1'b0);
        drive(1'b1, 16'h0001, 1'b0);
        chk("t2_locked", {63'd0, locked}, 64'd1);
        chk("t2_no_error", {56'd0, err_count}, 64'd0);

        // 3. Skip detection and first-failure capture
        for (int i = 2; i <= 5; i++) drive(1'b1, W'(i), 1'b0);
        drive(1'b1, 16'h0007, 1'b0);
        chk("t3_mismatch", {63'd0, mismatch}, 64'd1);
        chk("t3_err_count", {56'd0, err_count}, 64'd1);
        chk("t3_sticky", {63'd0, error_sticky}, 64'd1);
        chk("t3_first_bad", {48'd0, first_bad}, 64'h0007);
        chk("t3_first_exp", {48'd0, first_exp}, 64'h0006);
        chk("t3_unlocked", {63'd0, locked}, 64'd0);
        drive(1'b1, 16'h0008, 1'b0);
        chk("t3_pulse_one_cycle", {63'd0, mismatch}, 64'd0);
        drive(1'b1, 16'h0009, 1'b0);
        chk("t3_relocked", {63'd0, locked}, 64'd1);
        drive(1'b1, 16'h000B, 1'b0);
        chk("t3_err_count2", {56'd0, err_count}, 64'd2);
        chk("t3_first_bad_held", {48'd0, first_bad}, 64'h0007);
        for (int i = 12; i <= 16; i++) drive(1'b1, W'(i), 1'b0);

        // 4. Stall while the bus toggles
        chk("t4_locked_before", {63'd0, locked}, 64'd1);
        for (int i = 0; i < 5; i++) drive(1'b0, W'($urandom), 1'b0);
        drive(1'b1, 16'h0011, 1'b0);
        chk("t4_no_mismatch", {63'd0, mismatch}, 64'd0);
        chk("t4_err_count", {56'd0, err_count}, 64'd2);

        // 5. Saturation, then clear coinciding with an error
        val = 16'h0011;
        for (int i = 0; i < 300; i++) begin
            val = val + 16'd2;
            drive(1'b1, val, 1'b0);
            val = val + 16'd1;
            drive(1'b1, val, 1'b0);
            val = val + 16'd1;
            drive(1'b1, val, 1'b0);
        end
        chk("t5_saturated", {56'd0, err_count}, 64'hFF);
        chk("t5_first_bad_held", {48'd0, first_bad}, 64'h0007);
        val = val + 16'd2;
        bad = val;
        drive(1'b1, val, 1'b1);
        chk("t5_clear_err_count", {56'd0, err_count}, 64'd1);
        chk("t5_clear_sticky", {63'd0, error_sticky}, 64'd1);
        chk("t5_clear_first_bad", {48'd0, first_bad}, {48'd0, bad});
        chk("t5_clear_first_exp", {48'd0, first_exp}, {48'd0, W'(bad - 16'd1)});
        chk("t5_clear_mismatch", {63'd0, mismatch}, 64'd1);
        val = val + 16'd1;
        drive(1'b1, val, 1'b0);
        val = val + 16'd1;
        drive(1'b1, val, 1'b0);
        chk("t6_locked_before_reset", {63'd0, locked}, 64'd1);

        // 6. Asynchronous reset between clock edges
        #2;
        resetN = 1'b0;
        #1;
        chk("t6_async_reset", {5'd0, obs_vec}, 64'd0);
        model_reset();
        @(posedge clock);
        #1;
        resetN = 1'b1;
        drive(1'b1, 16'h1234, 1'b0);
        drive(1'b1, 16'h1235, 1'b0);
        drive(1'b1, 16'h1236, 1'b0);
        chk("t6_relocked", {63'd0, locked}, 64'd1);
        chk("t6_no_error", {63'd0, error_sticky}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
